platformniossdram_pll_reset_seq: RTL



---
 rtl/platformniossdram_pll_reset_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/platformniossdram_pll_reset_seq.sv
// Purpose : PLL reset sequencer; pulses pll_rst, waits for stable lock, then releases sys_rst.
// Latency : all outputs registered; sys_rst falls 1 + LOCK_STABLE_CYCLES edges after locked_s rises.
// Backpr. : none; free-running, driven only by refclk, rst and the PLL lock indication.
//
// Ports:
//   refclk          in   board reference clock (only clock, valid while the PLL is unlocked)
//   rst             in   asynchronous active-high reset
//   pll_locked      in   PLL lock indication, asynchronous to refclk
//   pll_rst         out  PLL reset, active high
//   sys_rst         out  system reset for downstream reset synchronizers, active high
//   ready           out  high only while the system is running on a stable lock
//   lock_loss_count out  lock losses seen while running, saturating at 255
//   timeout_count   out  lock-wait timeouts, saturating at 255
module platformniossdram_pll_reset_seq #(
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 65536,
   parameter int unsigned CNT_W              = 17
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [7:0] lock_loss_count,
   output logic [7:0] timeout_count
);

   typedef enum logic [1:0] {
      ST_PLL_RESET = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABILIZE = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_sync1;
   logic             r_locked_s;
   logic             w_timeout_evt;
   logic             w_loss_evt;

   // Two-flop synchronizer for the asynchronous lock indication.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_sync1    <= pll_locked;
         r_locked_s <= r_sync1;
      end
   end

   // Next-state logic. The counter defaults to zero, so every state change
   // (and RUN) clears it; only "stay" paths increment.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = '0;
      w_timeout_evt = 1'b0;
      w_loss_evt    = 1'b0;
      case (r_state)
         ST_PLL_RESET: begin
            // Lock is deliberately not looked at while the PLL is held in reset.
            if (r_cnt == C_PRST_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (r_locked_s) begin
               w_state_nxt = ST_STABILIZE;
            end else if (r_cnt == C_TO_LAST) begin
               w_state_nxt   = ST_PLL_RESET;
               w_timeout_evt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_STABILIZE: begin
            // A lock drop beats completion, so RUN is never entered on a bad edge.
            if (!r_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_cnt == C_STABLE_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_RUN: begin
            if (!r_locked_s) begin
               w_state_nxt = ST_PLL_RESET;
               w_loss_evt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_PLL_RESET;
         end
      endcase
   end

   // State, counter and outputs. Outputs are decoded from the next state so
   // they change on the same edge as the state itself.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_PLL_RESET;
         r_cnt           <= '0;
         pll_rst         <= 1'b1;
         sys_rst         <= 1'b1;
         ready           <= 1'b0;
         lock_loss_count <= 8'd0;
         timeout_count   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         pll_rst <= (w_state_nxt == ST_PLL_RESET);
         sys_rst <= (w_state_nxt != ST_RUN);
         ready   <= (w_state_nxt == ST_RUN);
         if (w_loss_evt && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
         end
         if (w_timeout_evt && (timeout_count != 8'hFF)) begin
            timeout_count <= timeout_count + 8'd1;
         end
      end
   end

endmodule
